// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-flow unit: flow_op codes and return-stack frame layout.
// A frame is {is_int, z, c, pc}, PC_W+3 bits wide, with the pc in the low bits.
package pc_seq_pkg;

  localparam logic [2:0] FLOW_INC  = 3'd0;
  localparam logic [2:0] FLOW_REL  = 3'd1;
  localparam logic [2:0] FLOW_JMP  = 3'd2;
  localparam logic [2:0] FLOW_CALL = 3'd3;
  localparam logic [2:0] FLOW_RET  = 3'd4;
  localparam logic [2:0] FLOW_RETI = 3'd5;
  localparam logic [2:0] FLOW_HALT = 3'd6;

  // Frame field offsets above the pc field.
  localparam int ENT_XTRA  = 3;
  localparam int ENT_C_OFS = 0;
  localparam int ENT_Z_OFS = 1;
  localparam int ENT_I_OFS = 2;

  function automatic int ent_w(input int pc_w);
    return pc_w + ENT_XTRA;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Parametrised LIFO holding return frames; storage is not reset, only the occupancy count.
// Push is ignored when full and pop when empty; callers decide the error policy.
module ret_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_dat,
  output logic [W-1:0]             top_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   sp
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic [AW:0]   sp_m1;

  assign full    = (sp_q == (AW+1)'(DEPTH));
  assign empty   = (sp_q == '0);
  assign sp      = sp_q;
  assign sp_m1   = sp_q - 1'b1;
  assign top_dat = mem_q[sp_m1[AW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[sp_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow unit: PC update, return stack, edge-latched masked interrupts with flag save/restore.
// Interrupt entry is taken only when no other stack op is in flight, so one push/pop per cycle.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int DEPTH      = 16,
  parameter int N_INT      = 8,
  parameter int VEC_BASE   = 1,
  parameter int VEC_STRIDE = 4,
  localparam int INT_W     = (N_INT > 1) ? $clog2(N_INT) : 1,
  localparam int SP_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [2:0]        flow_op,
  input  logic [PC_W-1:0]   target,
  input  logic [PC_W-1:0]   offset,
  input  logic [N_INT-1:0]  int_req,
  input  logic [N_INT-1:0]  int_mask,
  input  logic              gie_set,
  input  logic              gie_clr,
  input  logic              z_in,
  input  logic              c_in,
  output logic [PC_W-1:0]   pc,
  output logic              int_ack,
  output logic [INT_W-1:0]  int_id,
  output logic              flags_restore,
  output logic              z_out,
  output logic              c_out,
  output logic [SP_W-1:0]   sp,
  output logic              gie,
  output logic              stack_oflow,
  output logic              stack_uflow
);

  localparam int EW = ent_w(PC_W);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             gie_q, gie_d;
  logic [N_INT-1:0] pending_q, pending_d;
  logic [N_INT-1:0] req_prev_q, req_prev_d;
  logic             int_ack_q, int_ack_d;
  logic [INT_W-1:0] int_id_q, int_id_d;
  logic             flags_restore_q, flags_restore_d;
  logic             z_out_q, z_out_d;
  logic             c_out_q, c_out_d;
  logic             oflow_q, oflow_d;
  logic             uflow_q, uflow_d;

  logic             push, pop, full, empty;
  logic [EW-1:0]    push_dat, top_dat;
  logic [N_INT-1:0] active, pend_clr;
  logic [INT_W-1:0] win_idx;
  logic [PC_W-1:0]  seq_pc, vec_pc;
  logic             is_stack_op, take_int;
  logic             unused_frame_is_int;

  ret_stack #(.DEPTH(DEPTH), .W(EW)) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_dat (push_dat),
    .top_dat  (top_dat),
    .full     (full),
    .empty    (empty),
    .sp       (sp)
  );

  // A RET of an interrupt frame is legal, so the frame's is_int bit has no consumer.
  assign unused_frame_is_int = top_dat[PC_W+ENT_I_OFS];

  assign active      = pending_q & int_mask;
  assign is_stack_op = (flow_op == FLOW_CALL) || (flow_op == FLOW_RET) || (flow_op == FLOW_RETI);
  assign take_int    = gie_q && (|active) && !full && !is_stack_op;
  assign vec_pc      = PC_W'(VEC_BASE + VEC_STRIDE * int'(win_idx));

  always_comb begin
    win_idx = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (active[i]) win_idx = INT_W'(i);
    end
  end

  // Address the current flow_op would produce; also the return address on interrupt entry.
  always_comb begin
    case (flow_op)
      FLOW_REL:  seq_pc = pc_q + offset;
      FLOW_JMP,
      FLOW_CALL: seq_pc = target;
      FLOW_RET,
      FLOW_RETI: seq_pc = empty ? pc_q + PC_W'(1) : top_dat[PC_W-1:0];
      FLOW_HALT: seq_pc = pc_q;
      default:   seq_pc = pc_q + PC_W'(1);
    endcase
  end

  always_comb begin
    pc_d            = pc_q;
    gie_d           = gie_q;
    req_prev_d      = int_req;
    pend_clr        = '0;
    int_ack_d       = 1'b0;
    int_id_d        = int_id_q;
    flags_restore_d = 1'b0;
    z_out_d         = z_out_q;
    c_out_d         = c_out_q;
    oflow_d         = oflow_q;
    uflow_d         = uflow_q;
    push            = 1'b0;
    pop             = 1'b0;
    push_dat        = {1'b0, z_in, c_in, pc_q + PC_W'(1)};

    if (!hold) begin
      if (gie_clr)      gie_d = 1'b0;
      else if (gie_set) gie_d = 1'b1;

      if (take_int) begin
        push             = 1'b1;
        push_dat         = {1'b1, z_in, c_in, seq_pc};
        pc_d             = vec_pc;
        pend_clr[win_idx] = 1'b1;
        gie_d            = 1'b0;
        int_ack_d        = 1'b1;
        int_id_d         = win_idx;
      end else begin
        pc_d = seq_pc;
        case (flow_op)
          FLOW_CALL: begin
            if (full) oflow_d = 1'b1;
            else      push    = 1'b1;
          end
          FLOW_RET, FLOW_RETI: begin
            if (empty) begin
              uflow_d = 1'b1;
            end else begin
              pop = 1'b1;
              if (flow_op == FLOW_RETI) begin
                flags_restore_d = 1'b1;
                z_out_d         = top_dat[PC_W+ENT_Z_OFS];
                c_out_d         = top_dat[PC_W+ENT_C_OFS];
              end
            end
            if (flow_op == FLOW_RETI) gie_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // A fresh edge on the line being serviced re-arms it.
    pending_d = (pending_q & ~pend_clr) | (int_req & ~req_prev_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= '0;
      gie_q           <= 1'b0;
      pending_q       <= '0;
      req_prev_q      <= '0;
      int_ack_q       <= 1'b0;
      int_id_q        <= '0;
      flags_restore_q <= 1'b0;
      z_out_q         <= 1'b0;
      c_out_q         <= 1'b0;
      oflow_q         <= 1'b0;
      uflow_q         <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      gie_q           <= gie_d;
      pending_q       <= pending_d;
      req_prev_q      <= req_prev_d;
      int_ack_q       <= int_ack_d;
      int_id_q        <= int_id_d;
      flags_restore_q <= flags_restore_d;
      z_out_q         <= z_out_d;
      c_out_q         <= c_out_d;
      oflow_q         <= oflow_d;
      uflow_q         <= uflow_d;
    end
  end

  assign pc            = pc_q;
  assign gie           = gie_q;
  assign int_ack       = int_ack_q;
  assign int_id        = int_id_q;
  assign flags_restore = flags_restore_q;
  assign z_out         = z_out_q;
  assign c_out         = c_out_q;
  assign stack_oflow   = oflow_q;
  assign stack_uflow   = uflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 4-deep return stack and default vector layout.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic [2:0]  flow_op;
  logic [9:0]  target, offset;
  logic [7:0]  int_req, int_mask;
  logic        gie_set, gie_clr, z_in, c_in;
  logic [9:0]  pc;
  logic        int_ack;
  logic [2:0]  int_id;
  logic        flags_restore, z_out, c_out;
  logic [2:0]  sp;
  logic        gie, stack_oflow, stack_uflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(10), .DEPTH(4), .N_INT(8), .VEC_BASE(1), .VEC_STRIDE(4)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flow_op(flow_op), .target(target),
    .offset(offset), .int_req(int_req), .int_mask(int_mask), .gie_set(gie_set),
    .gie_clr(gie_clr), .z_in(z_in), .c_in(c_in), .pc(pc), .int_ack(int_ack),
    .int_id(int_id), .flags_restore(flags_restore), .z_out(z_out), .c_out(c_out),
    .sp(sp), .gie(gie), .stack_oflow(stack_oflow), .stack_uflow(stack_uflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] op);
    flow_op = op;
    tick();
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flow_op = FLOW_INC; target = '0; offset = '0;
    int_req = '0; int_mask = '0; gie_set = 1'b0; gie_clr = 1'b0; z_in = 1'b0; c_in = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 0);       chk("rst_sp", sp, 0);        chk("rst_gie", gie, 0);
    chk("rst_ack", int_ack, 0); chk("rst_id", int_id, 0);    chk("rst_fr", flags_restore, 0);
    chk("rst_of", stack_oflow, 0); chk("rst_uf", stack_uflow, 0);
    reset = 1'b0;

    // Sequential flow, relative and absolute jumps, wrap.
    step(FLOW_INC); chk("inc1", pc, 1);
    step(FLOW_INC); chk("inc2", pc, 2);
    step(FLOW_INC); chk("inc3", pc, 3);
    offset = 10'h3FE; step(FLOW_REL); chk("rel_m2", pc, 1);
    target = 10'h200; step(FLOW_JMP); chk("jmp", pc, 10'h200);
    target = 10'h3FF; step(FLOW_JMP); chk("jmp_max", pc, 10'h3FF);
    step(FLOW_INC); chk("inc_wrap", pc, 0);
    step(7);        chk("rsvd_inc", pc, 1);

    // Call / return.
    target = 10'h010; step(FLOW_JMP);
    target = 10'h050; step(FLOW_CALL); chk("call_pc", pc, 10'h050); chk("call_sp", sp, 1);
    step(FLOW_RET); chk("ret_pc", pc, 10'h011); chk("ret_sp", sp, 0);

    // Interrupt entry from INC, RETI flag restore, then the second pending line.
    target = 10'h020; int_req = 8'h0A; int_mask = 8'hFF; gie_set = 1'b1;
    step(FLOW_JMP); chk("gie_on", gie, 1); chk("jmp20", pc, 10'h020); chk("no_ack_yet", int_ack, 0);
    gie_set = 1'b0; z_in = 1'b1; c_in = 1'b0;
    step(FLOW_INC);
    chk("ent1_pc", pc, 5); chk("ent1_ack", int_ack, 1); chk("ent1_id", int_id, 1);
    chk("ent1_sp", sp, 1); chk("ent1_gie", gie, 0);
    z_in = 1'b0; c_in = 1'b1;
    step(FLOW_RETI);
    chk("reti_pc", pc, 10'h021); chk("reti_fr", flags_restore, 1); chk("reti_z", z_out, 1);
    chk("reti_c", c_out, 0); chk("reti_gie", gie, 1); chk("reti_ack", int_ack, 0); chk("reti_sp", sp, 0);
    step(FLOW_INC);
    chk("ent3_pc", pc, 13); chk("ent3_id", int_id, 3); chk("ent3_ack", int_ack, 1); chk("ent3_fr", flags_restore, 0);
    step(FLOW_RETI);
    chk("reti3_pc", pc, 10'h022); chk("reti3_z", z_out, 0); chk("reti3_c", c_out, 1);

    // Interrupt arriving alongside CALL is deferred one cycle.
    int_req = 8'h00; step(FLOW_INC); chk("pc23", pc, 10'h023);
    int_req = 8'h01; step(FLOW_INC); chk("pc24", pc, 10'h024);
    target = 10'h100; step(FLOW_CALL);
    chk("dcall_pc", pc, 10'h100); chk("dcall_sp", sp, 1); chk("dcall_ack", int_ack, 0);
    step(FLOW_INC);
    chk("dent_pc", pc, 1); chk("dent_sp", sp, 2); chk("dent_ack", int_ack, 1); chk("dent_id", int_id, 0);
    step(FLOW_RETI); chk("dreti_pc", pc, 10'h101); chk("dreti_sp", sp, 1); chk("dreti_fr", flags_restore, 1);
    step(FLOW_RET);  chk("dret_pc", pc, 10'h025); chk("dret_sp", sp, 0); chk("dret_fr", flags_restore, 0);

    // Overflow on the fifth CALL, underflow on the fifth RET.
    for (int i = 0; i < 4; i++) begin
      target = 10'h300 + 10'(i); step(FLOW_CALL);
    end
    chk("fill_sp", sp, 4); chk("fill_of", stack_oflow, 0);
    target = 10'h304; step(FLOW_CALL);
    chk("of_pc", pc, 10'h304); chk("of_sp", sp, 4); chk("of_flag", stack_oflow, 1);
    step(FLOW_RET); chk("pop4", pc, 10'h303);
    step(FLOW_RET); chk("pop3", pc, 10'h302);
    step(FLOW_RET); chk("pop2", pc, 10'h301);
    step(FLOW_RET); chk("pop1", pc, 10'h026); chk("pop1_uf", stack_uflow, 0);
    step(FLOW_RET);
    chk("uf_pc", pc, 10'h027); chk("uf_flag", stack_uflow, 1); chk("uf_sp", sp, 0);
    gie_clr = 1'b1; step(FLOW_INC); chk("gie_clr", gie, 0); gie_clr = 1'b0;
    step(FLOW_RETI);
    chk("ufi_pc", pc, 10'h029); chk("ufi_gie", gie, 1); chk("ufi_fr", flags_restore, 0);
    chk("of_sticky", stack_oflow, 1);

    // HALT waits for an interrupt; a held request yields only one entry.
    int_req = 8'h04; step(FLOW_HALT); chk("halt_pc", pc, 10'h029);
    step(FLOW_HALT);
    chk("wfi_pc", pc, 9); chk("wfi_ack", int_ack, 1); chk("wfi_id", int_id, 2);
    for (int i = 0; i < 8; i++) begin
      step(FLOW_HALT); chk("wfi_hold_pc", pc, 9); chk("wfi_once", int_ack, 0);
    end
    step(FLOW_RETI); chk("wfi_ret", pc, 10'h029); chk("wfi_sp", sp, 0);

    // Edge captured under hold, entry once hold drops.
    int_req = 8'h00; step(FLOW_HALT);
    hold = 1'b1; int_req = 8'h20;
    step(FLOW_INC); chk("hold_pc", pc, 10'h029); chk("hold_ack", int_ack, 0);
    step(FLOW_INC); chk("hold_pc2", pc, 10'h029); chk("hold_sp", sp, 0);
    hold = 1'b0;
    step(FLOW_INC);
    chk("hent_pc", pc, 21); chk("hent_id", int_id, 5); chk("hent_ack", int_ack, 1); chk("hent_sp", sp, 1);

    // Reset in the middle of a service routine.
    reset = 1'b1; step(FLOW_INC);
    chk("mrst_pc", pc, 0); chk("mrst_sp", sp, 0); chk("mrst_gie", gie, 0);
    chk("mrst_of", stack_oflow, 0); chk("mrst_uf", stack_uflow, 0); chk("mrst_ack", int_ack, 0);
    reset = 1'b0;
    step(FLOW_RET); chk("mrst_ret", pc, 1); chk("mrst_uf2", stack_uflow, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
